burst_mem_master: RTL and testbench
===================================

# burst_mem_master

- Initiator for the single-port synchronous memory (Din/Addr/R_W/Valid/Dout, read data registered one cycle after the sampled request).
- Accepts one burst command at a time (start address, length, direction) and moves data between the memory and the design:
  - write bursts are fed from a valid/ready write-data stream;
  - read bursts are delivered on a valid/ready read-data stream through a 4-entry buffer that absorbs memory latency under backpressure.
- Sits between processing blocks and the memory instance.

## Interface
- WIDTH, 8, memory address width in bits
- DinLength, 32, data word width
- LenWidth, 8, burst length field width
- Clk  in  1  single clock, all logic on rising edge
- Reset  in  1  synchronous, active-high
- Cmd_Valid  in  1  command offered
- Cmd_Ready  out  1  high only in IDLE
- Cmd_R_W  in  1  0 = read burst, 1 = write burst (memory encoding)
- Cmd_Addr  in  WIDTH  start address
- Cmd_Len  in  LenWidth  number of words, 0 allowed
- Wr_Data  in  DinLength  write word
- Wr_Valid  in  1  write word offered
- Wr_Ready  out  1  high only in WRITE
- Rd_Data  out  DinLength  buffer head word
- Rd_Valid  out  1  buffer not empty
- Rd_Ready  in  1  consumer accepts head
- Mem_Din  out  DinLength  to memory Din
- Mem_Addr  out  WIDTH  to memory Addr
- Mem_R_W  out  1  to memory R_W
- Mem_Valid  out  1  to memory Valid
- Mem_Dout  in  DinLength  from memory Dout
- Busy  out  1  state != IDLE
- Done  out  1  one-cycle pulse at burst completion

## Operation
States and transitions:
- IDLE: Cmd_Ready=1. On Cmd_Valid, latch addr/len/dir.
  - Len=0 -> DONE.
  - Cmd_R_W=1 -> WRITE.
  - Cmd_R_W=0 -> READ.
- WRITE: each Wr_Valid&Wr_Ready handshake registers Mem_Din=Wr_Data, Mem_Addr=cur, Mem_R_W=1, Mem_Valid=1 for exactly the next cycle; cur+1, remaining-1. Handshake on the last word -> DONE.
- READ: issue allowed when (buffer occupancy + reads in flight) < 4.
  - Issue registers Mem_Addr=cur, Mem_R_W=0, Mem_Valid=1 for the next cycle.
  - Last issue -> DRAIN.
- DRAIN: stay until in-flight=0 and buffer empty -> DONE.
- DONE: Done=1 for one cycle -> IDLE.

Data and counter rules:
- In-flight tracking: two-stage valid shift (issued, in-memory). Mem_Dout is pushed into the buffer in the cycle the second stage is set.
- Address increments modulo 2^WIDTH: 2^WIDTH-1 wraps to 0 mid-burst with no error.
- Remaining-count is LenWidth bits and never underflows.
- Mem_Valid=0 in all cycles without an issued access. Mem_Din/Mem_Addr hold their last value when idle.
- Cmd_Valid outside IDLE, Wr_Valid outside WRITE, and Rd_Ready with an empty buffer are ignored.
- Buffer push and pop in the same cycle is legal. The credit rule guarantees no overflow.

## Timing
Reset:
- Reset sampled high: next cycle state=IDLE, Cmd_Ready=1, Wr_Ready=0, Rd_Valid=0, Busy=0, Done=0, Mem_Valid=0, Mem_R_W=0, Mem_Addr=0, Mem_Din=0.
- Buffer and in-flight stages cleared.
- Reset mid-burst abandons the burst without a Done pulse. Data still returning from the memory is discarded.

Latency:
- Write: handshake at cycle t -> Mem_Valid in t+1. Done is high in the same cycle as the last Mem_Valid.
- Read: issue decision at t -> Mem_Valid at t+1 -> Mem_Dout valid at t+2 -> Rd_Valid at t+3.
- With Rd_Ready held high, throughput is 1 word/cycle.
- Done fires the cycle after the last word is popped.
- Cmd_Ready returns high the cycle after Done.
- Len=0: accept at t, Done at t+1, no memory traffic.

## Structure
- Shared package:
  - FSM state encoding: IDLE, WRITE, READ, DRAIN, DONE.
  - Read-buffer depth constant (4).
  - R_W encoding constants: READ=0, WRITE=1, shared with the memory.
- One sub-module: `burst_rd_fifo`, a 4-entry synchronous FIFO with push, pop, count, synchronous clear.

## Test plan
- Write burst Addr=0x10, Len=3, Wr_Valid continuous with 0xA0,0xA1,0xA2 -> Mem_Valid three consecutive cycles, R_W=1, addresses 0x10–0x12. Done coincides with the third write.
- Read back Addr=0x10, Len=3, Rd_Ready=1 -> first Rd_Valid 3 cycles after the first issue, data 0xA0,0xA1,0xA2 back-to-back, then Done.
- Read Len=8 with Rd_Ready low for 10 cycles -> at most 4 words buffered, issues stall, no data lost or duplicated after release.
- Write Addr=0xFE, Len=4 -> addresses 0xFE,0xFF,0x00,0x01.
- Len=0 command and Cmd_Valid pulsed while Busy -> Done one cycle after accept, no Mem_Valid; busy command ignored.
- Reset during READ with 2 words in flight -> Rd_Valid=0, Mem_Valid=0 the next cycle, no Done. Cmd_Ready=1 after reset release.

Source files
------------

// File: rtl/burst_mem_master_pkg.sv
// ---------------------------------------------------------------------------
// burst_mem_master_pkg
// Shared definitions for the burst memory master and its read buffer:
//   - FSM state encoding
//   - read-buffer depth and the pointer/count widths derived from it
//   - R_W encoding shared with the single-port memory (0 = read, 1 = write)
// ---------------------------------------------------------------------------
package burst_mem_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int RD_BUF_DEPTH = 4;
  localparam int RD_BUF_PTR_W = 2;
  // Count has to represent 0..RD_BUF_DEPTH inclusive.
  localparam int RD_BUF_CNT_W = 3;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/burst_rd_fifo.sv
// ---------------------------------------------------------------------------
// burst_rd_fifo
// Small synchronous FIFO that buffers read data returning from the memory
// so that the consumer can apply backpressure without losing words.
//
// Ports:
//   Clk        rising-edge clock
//   Clear      synchronous clear; empties the buffer (wins over push/pop)
//   Push       write Push_Data into the tail (ignored when full)
//   Push_Data  word to store
//   Pop        drop the head word (ignored when empty)
//   Head       current head word (valid when Count != 0)
//   Count      number of stored words, 0..RD_BUF_DEPTH
// ---------------------------------------------------------------------------
module burst_rd_fifo
  import burst_mem_master_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                    Clk,
  input  logic                    Clear,
  input  logic                    Push,
  input  logic [DATA_W-1:0]       Push_Data,
  input  logic                    Pop,
  output logic [DATA_W-1:0]       Head,
  output logic [RD_BUF_CNT_W-1:0] Count
);

  logic [DATA_W-1:0]       storage [RD_BUF_DEPTH];
  logic [RD_BUF_PTR_W-1:0] wr_ptr;
  logic [RD_BUF_PTR_W-1:0] rd_ptr;
  logic                    push_ok;
  logic                    pop_ok;

  assign push_ok = Push && (Count != RD_BUF_CNT_W'(RD_BUF_DEPTH));
  assign pop_ok  = Pop && (Count != '0);
  assign Head    = storage[rd_ptr];

  // Pointers and occupancy; a simultaneous push and pop leaves the count alone.
  always_ff @(posedge Clk) begin
    if (Clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + RD_BUF_PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + RD_BUF_PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   Count <= Count + RD_BUF_CNT_W'(1);
        2'b01:   Count <= Count - RD_BUF_CNT_W'(1);
        default: Count <= Count;
      endcase
    end
  end

  // Data storage needs no reset; the count alone decides what is valid.
  always_ff @(posedge Clk) begin
    if (push_ok && !Clear) storage[wr_ptr] <= Push_Data;
  end

endmodule

// File: rtl/burst_mem_master.sv
// ---------------------------------------------------------------------------
// burst_mem_master
// Burst initiator for a single-port synchronous memory whose read data
// appears on Dout one cycle after the request is sampled. Takes one burst
// command at a time and either streams write words into the memory or
// streams read words out through a 4-entry buffer.
//
// Ports:
//   Clk, Reset                 clock, synchronous active-high reset
//   Cmd_Valid/Cmd_Ready        command handshake (ready only when idle)
//   Cmd_R_W, Cmd_Addr, Cmd_Len burst direction (1 = write), start, length
//   Wr_Data/Wr_Valid/Wr_Ready  write-data stream (ready only in WRITE)
//   Rd_Data/Rd_Valid/Rd_Ready  read-data stream from the buffer head
//   Mem_Din/Addr/R_W/Valid     registered request to the memory
//   Mem_Dout                   read data from the memory
//   Busy                       a burst is in progress
//   Done                       one-cycle pulse when a burst completes
// ---------------------------------------------------------------------------
module burst_mem_master
  import burst_mem_master_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DinLength = 32,
  parameter int LenWidth  = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Cmd_Valid,
  output logic                 Cmd_Ready,
  input  logic                 Cmd_R_W,
  input  logic [WIDTH-1:0]     Cmd_Addr,
  input  logic [LenWidth-1:0]  Cmd_Len,
  input  logic [DinLength-1:0] Wr_Data,
  input  logic                 Wr_Valid,
  output logic                 Wr_Ready,
  output logic [DinLength-1:0] Rd_Data,
  output logic                 Rd_Valid,
  input  logic                 Rd_Ready,
  output logic [DinLength-1:0] Mem_Din,
  output logic [WIDTH-1:0]     Mem_Addr,
  output logic                 Mem_R_W,
  output logic                 Mem_Valid,
  input  logic [DinLength-1:0] Mem_Dout,
  output logic                 Busy,
  output logic                 Done
);

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0]        cur_addr;
  logic [LenWidth-1:0]     remaining;
  logic                    issued_s1;
  logic                    in_mem_s2;
  logic [RD_BUF_CNT_W-1:0] buf_count;
  logic [RD_BUF_CNT_W-1:0] credit_used;
  logic                    credit_ok;
  logic                    buf_pop;
  logic                    last_word;
  logic                    accept;
  logic                    wr_fire;
  logic                    rd_issue;

  // A read may only be issued when every word already owed to the buffer
  // (stored or still travelling through the memory) leaves room for it.
  assign credit_used = buf_count + RD_BUF_CNT_W'(issued_s1) + RD_BUF_CNT_W'(in_mem_s2);
  assign credit_ok   = credit_used < RD_BUF_CNT_W'(RD_BUF_DEPTH);
  assign last_word   = remaining == LenWidth'(1);
  assign Rd_Valid    = buf_count != '0;
  assign buf_pop     = Rd_Valid && Rd_Ready;
  assign Busy        = state != ST_IDLE;

  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state and handshake decode. DRAIN leaves as soon as the last word
  // is being popped so that Done lands in the cycle right after that pop.
  always_comb begin
    next_state = state;
    Cmd_Ready  = 1'b0;
    Wr_Ready   = 1'b0;
    Done       = 1'b0;
    accept     = 1'b0;
    wr_fire    = 1'b0;
    rd_issue   = 1'b0;
    case (state)
      ST_IDLE: begin
        Cmd_Ready = 1'b1;
        if (Cmd_Valid) begin
          accept = 1'b1;
          if (Cmd_Len == '0)          next_state = ST_DONE;
          else if (Cmd_R_W == RW_WRITE) next_state = ST_WRITE;
          else                        next_state = ST_READ;
        end
      end
      ST_WRITE: begin
        Wr_Ready = 1'b1;
        if (Wr_Valid) begin
          wr_fire = 1'b1;
          if (last_word) next_state = ST_DONE;
        end
      end
      ST_READ: begin
        if (credit_ok) begin
          rd_issue = 1'b1;
          if (last_word) next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!issued_s1 && !in_mem_s2 &&
            ((buf_count == '0) || ((buf_count == RD_BUF_CNT_W'(1)) && buf_pop)))
          next_state = ST_DONE;
      end
      ST_DONE: begin
        Done       = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Burst bookkeeping and the registered memory request. The two in-flight
  // stages follow a read from issue to the cycle its data sits on Mem_Dout;
  // clearing them on reset discards anything still coming back.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cur_addr  <= '0;
      remaining <= '0;
      issued_s1 <= 1'b0;
      in_mem_s2 <= 1'b0;
      Mem_Valid <= 1'b0;
      Mem_R_W   <= RW_READ;
      Mem_Addr  <= '0;
      Mem_Din   <= '0;
    end else begin
      Mem_Valid <= wr_fire || rd_issue;
      issued_s1 <= rd_issue;
      in_mem_s2 <= issued_s1;
      if (accept) begin
        cur_addr  <= Cmd_Addr;
        remaining <= Cmd_Len;
      end else if (wr_fire || rd_issue) begin
        cur_addr <= cur_addr + WIDTH'(1);
        if (remaining != '0) remaining <= remaining - LenWidth'(1);
      end
      if (wr_fire) begin
        Mem_Din  <= Wr_Data;
        Mem_Addr <= cur_addr;
        Mem_R_W  <= RW_WRITE;
      end else if (rd_issue) begin
        Mem_Addr <= cur_addr;
        Mem_R_W  <= RW_READ;
      end
    end
  end

  burst_rd_fifo #(
    .DATA_W(DinLength)
  ) u_rd_fifo (
    .Clk      (Clk),
    .Clear    (Reset),
    .Push     (in_mem_s2),
    .Push_Data(Mem_Dout),
    .Pop      (buf_pop),
    .Head     (Rd_Data),
    .Count    (buf_count)
  );

endmodule

// File: tb/tb_burst_mem_master.sv
// ---------------------------------------------------------------------------
// tb_burst_mem_master
// Directed bench for burst_mem_master with a behavioural single-port memory
// (read data registered one cycle after the sampled request). Expected
// values are written out by hand for each step.
// ---------------------------------------------------------------------------
module tb_burst_mem_master;

  localparam int WIDTH     = 8;
  localparam int DinLength = 32;
  localparam int LenWidth  = 8;

  logic                 Clk = 1'b0;
  logic                 Reset;
  logic                 Cmd_Valid;
  logic                 Cmd_Ready;
  logic                 Cmd_R_W;
  logic [WIDTH-1:0]     Cmd_Addr;
  logic [LenWidth-1:0]  Cmd_Len;
  logic [DinLength-1:0] Wr_Data;
  logic                 Wr_Valid;
  logic                 Wr_Ready;
  logic [DinLength-1:0] Rd_Data;
  logic                 Rd_Valid;
  logic                 Rd_Ready;
  logic [DinLength-1:0] Mem_Din;
  logic [WIDTH-1:0]     Mem_Addr;
  logic                 Mem_R_W;
  logic                 Mem_Valid;
  logic [DinLength-1:0] Mem_Dout;
  logic                 Busy;
  logic                 Done;

  int vectors     = 0;
  int miscompares = 0;
  int memValidCount = 0;

  logic [DinLength-1:0] memArray [256];

  burst_mem_master #(
    .WIDTH    (WIDTH),
    .DinLength(DinLength),
    .LenWidth (LenWidth)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Cmd_Valid(Cmd_Valid),
    .Cmd_Ready(Cmd_Ready),
    .Cmd_R_W  (Cmd_R_W),
    .Cmd_Addr (Cmd_Addr),
    .Cmd_Len  (Cmd_Len),
    .Wr_Data  (Wr_Data),
    .Wr_Valid (Wr_Valid),
    .Wr_Ready (Wr_Ready),
    .Rd_Data  (Rd_Data),
    .Rd_Valid (Rd_Valid),
    .Rd_Ready (Rd_Ready),
    .Mem_Din  (Mem_Din),
    .Mem_Addr (Mem_Addr),
    .Mem_R_W  (Mem_R_W),
    .Mem_Valid(Mem_Valid),
    .Mem_Dout (Mem_Dout),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 Clk = ~Clk;

  // Behavioural single-port memory: writes land on the edge, read data is
  // registered onto Mem_Dout by the same edge that samples the request.
  always @(posedge Clk) begin
    if (Mem_Valid === 1'b1) begin
      if (Mem_R_W) memArray[Mem_Addr] <= Mem_Din;
      else         Mem_Dout <= memArray[Mem_Addr];
    end
  end

  // Running count of memory accesses seen on the bus.
  always @(posedge Clk) begin
    if (Mem_Valid === 1'b1) memValidCount <= memValidCount + 1;
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic applyStimulus(input logic cv, input logic rw, input logic [7:0] addr,
                               input logic [7:0] len, input logic wv,
                               input logic [31:0] wd, input logic rr);
    Cmd_Valid = cv;
    Cmd_R_W   = rw;
    Cmd_Addr  = addr;
    Cmd_Len   = len;
    Wr_Valid  = wv;
    Wr_Data   = wd;
    Rd_Ready  = rr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int got;
    int lastPop;
    int doneAt;
    bit doneSeen;
    bit sawValid;
    bit sawDone;

    for (int i = 0; i < 256; i++) memArray[i] = 32'hC000_0000 | 32'(i);

    // Reset state
    Reset = 1'b1;
    applyStimulus(0, 0, 8'h00, 8'd0, 0, 32'h0, 0);
    tick();
    tick();
    checkOutput("rst_cmd_ready", Cmd_Ready, 1);
    checkOutput("rst_wr_ready",  Wr_Ready,  0);
    checkOutput("rst_rd_valid",  Rd_Valid,  0);
    checkOutput("rst_busy",      Busy,      0);
    checkOutput("rst_done",      Done,      0);
    checkOutput("rst_mem_valid", Mem_Valid, 0);
    checkOutput("rst_mem_rw",    Mem_R_W,   0);
    checkOutput("rst_mem_addr",  Mem_Addr,  0);
    checkOutput("rst_mem_din",   Mem_Din,   0);
    Reset = 1'b0;
    tick();

    // Write burst 0x10, len 3, continuous data A0..A2
    applyStimulus(1, 1, 8'h10, 8'd3, 1, 32'hA0, 0);
    checkOutput("wr1_cmd_ready", Cmd_Ready, 1);
    tick();
    applyStimulus(0, 1, 8'h10, 8'd3, 1, 32'hA0, 0);
    checkOutput("wr1_wr_ready", Wr_Ready, 1);
    checkOutput("wr1_busy", Busy, 1);
    checkOutput("wr1_no_access_yet", Mem_Valid, 0);
    tick();
    applyStimulus(0, 1, 8'h10, 8'd3, 1, 32'hA1, 0);
    checkOutput("wr1_v0", Mem_Valid, 1);
    checkOutput("wr1_rw0", Mem_R_W, 1);
    checkOutput("wr1_a0", Mem_Addr, 32'h10);
    checkOutput("wr1_d0", Mem_Din, 32'hA0);
    checkOutput("wr1_done0", Done, 0);
    tick();
    applyStimulus(0, 1, 8'h10, 8'd3, 1, 32'hA2, 0);
    checkOutput("wr1_v1", Mem_Valid, 1);
    checkOutput("wr1_a1", Mem_Addr, 32'h11);
    checkOutput("wr1_d1", Mem_Din, 32'hA1);
    tick();
    applyStimulus(0, 1, 8'h10, 8'd3, 0, 32'hA2, 0);
    checkOutput("wr1_v2", Mem_Valid, 1);
    checkOutput("wr1_a2", Mem_Addr, 32'h12);
    checkOutput("wr1_d2", Mem_Din, 32'hA2);
    checkOutput("wr1_done_with_last", Done, 1);
    tick();
    checkOutput("wr1_idle_mem_valid", Mem_Valid, 0);
    checkOutput("wr1_idle_done", Done, 0);
    checkOutput("wr1_idle_cmd_ready", Cmd_Ready, 1);
    checkOutput("wr1_addr_holds", Mem_Addr, 32'h12);

    // Read back 0x10, len 3, consumer always ready
    applyStimulus(1, 0, 8'h10, 8'd3, 0, 32'h0, 1);
    tick();
    applyStimulus(0, 0, 8'h10, 8'd3, 0, 32'h0, 1);
    checkOutput("rd1_no_access_yet", Mem_Valid, 0);
    tick();
    checkOutput("rd1_v0", Mem_Valid, 1);
    checkOutput("rd1_rw0", Mem_R_W, 0);
    checkOutput("rd1_a0", Mem_Addr, 32'h10);
    tick();
    checkOutput("rd1_a1", Mem_Addr, 32'h11);
    checkOutput("rd1_not_valid_yet", Rd_Valid, 0);
    tick();
    checkOutput("rd1_a2", Mem_Addr, 32'h12);
    checkOutput("rd1_valid0", Rd_Valid, 1);
    checkOutput("rd1_data0", Rd_Data, 32'hA0);
    tick();
    checkOutput("rd1_valid1", Rd_Valid, 1);
    checkOutput("rd1_data1", Rd_Data, 32'hA1);
    checkOutput("rd1_no_access", Mem_Valid, 0);
    tick();
    checkOutput("rd1_valid2", Rd_Valid, 1);
    checkOutput("rd1_data2", Rd_Data, 32'hA2);
    checkOutput("rd1_done_early", Done, 0);
    tick();
    checkOutput("rd1_done", Done, 1);
    checkOutput("rd1_empty", Rd_Valid, 0);
    tick();
    checkOutput("rd1_cmd_ready_back", Cmd_Ready, 1);
    checkOutput("rd1_done_cleared", Done, 0);

    // Read 0x40, len 8, consumer stalled for 10 cycles
    base = memValidCount;
    applyStimulus(1, 0, 8'h40, 8'd8, 0, 32'h0, 0);
    tick();
    applyStimulus(0, 0, 8'h40, 8'd8, 0, 32'h0, 0);
    repeat (9) tick();
    checkOutput("stall_rd_valid", Rd_Valid, 1);
    checkOutput("stall_head", Rd_Data, 32'hC000_0040);
    checkOutput("stall_no_issue", Mem_Valid, 0);
    checkOutput("stall_issued_4", 32'(memValidCount - base), 4);
    checkOutput("stall_busy", Busy, 1);
    applyStimulus(0, 0, 8'h40, 8'd8, 0, 32'h0, 1);
    got = 0;
    lastPop = -1;
    doneAt = -1;
    doneSeen = 1'b0;
    for (int cyc = 0; cyc < 40 && !doneSeen; cyc++) begin
      if (Done === 1'b1) begin
        doneSeen = 1'b1;
        doneAt = cyc;
      end else begin
        if (Rd_Valid === 1'b1) begin
          checkOutput($sformatf("stall_word%0d", got), Rd_Data, 32'hC000_0040 + 32'(got));
          got++;
          lastPop = cyc;
        end
        tick();
      end
    end
    checkOutput("stall_done_seen", doneSeen, 1);
    checkOutput("stall_word_count", got, 8);
    checkOutput("stall_done_after_pop", doneAt, lastPop + 1);
    checkOutput("stall_accesses", 32'(memValidCount - base), 8);
    tick();
    applyStimulus(0, 0, 8'h00, 8'd0, 0, 32'h0, 0);

    // Write 0xFE, len 4 across the address wrap, with a command pulsed mid-burst
    base = memValidCount;
    applyStimulus(1, 1, 8'hFE, 8'd4, 1, 32'hB0, 0);
    tick();
    applyStimulus(0, 1, 8'hFE, 8'd4, 1, 32'hB0, 0);
    tick();
    applyStimulus(1, 0, 8'h30, 8'd2, 1, 32'hB1, 0);
    checkOutput("wrap_a0", Mem_Addr, 32'hFE);
    checkOutput("wrap_d0", Mem_Din, 32'hB0);
    tick();
    applyStimulus(0, 1, 8'hFE, 8'd4, 1, 32'hB2, 0);
    checkOutput("wrap_a1", Mem_Addr, 32'hFF);
    checkOutput("wrap_d1", Mem_Din, 32'hB1);
    tick();
    applyStimulus(0, 1, 8'hFE, 8'd4, 1, 32'hB3, 0);
    checkOutput("wrap_a2", Mem_Addr, 32'h00);
    checkOutput("wrap_d2", Mem_Din, 32'hB2);
    tick();
    applyStimulus(0, 1, 8'hFE, 8'd4, 0, 32'hB3, 0);
    checkOutput("wrap_a3", Mem_Addr, 32'h01);
    checkOutput("wrap_d3", Mem_Din, 32'hB3);
    checkOutput("wrap_done", Done, 1);
    tick();
    checkOutput("wrap_idle", Busy, 0);
    tick();
    checkOutput("busy_cmd_ignored", Busy, 0);
    checkOutput("busy_cmd_no_access", Mem_Valid, 0);
    checkOutput("wrap_accesses", 32'(memValidCount - base), 4);

    // Zero-length command, then a command offered while in DONE
    base = memValidCount;
    applyStimulus(1, 1, 8'h20, 8'd0, 0, 32'h0, 0);
    tick();
    applyStimulus(1, 1, 8'h20, 8'd5, 0, 32'h0, 0);
    checkOutput("len0_done", Done, 1);
    checkOutput("len0_busy", Busy, 1);
    checkOutput("len0_cmd_ready", Cmd_Ready, 0);
    checkOutput("len0_no_access", Mem_Valid, 0);
    tick();
    applyStimulus(0, 0, 8'h00, 8'd0, 0, 32'h0, 0);
    checkOutput("len0_done_cleared", Done, 0);
    checkOutput("len0_idle", Busy, 0);
    tick();
    checkOutput("len0_still_idle", Busy, 0);
    checkOutput("len0_accesses", 32'(memValidCount - base), 0);

    // Reset while two reads are in flight
    applyStimulus(1, 0, 8'h40, 8'd8, 0, 32'h0, 0);
    tick();
    applyStimulus(0, 0, 8'h40, 8'd8, 0, 32'h0, 0);
    tick();
    tick();
    checkOutput("rstmid_access", Mem_Valid, 1);
    Reset = 1'b1;
    tick();
    checkOutput("rstmid_rd_valid", Rd_Valid, 0);
    checkOutput("rstmid_mem_valid", Mem_Valid, 0);
    checkOutput("rstmid_done", Done, 0);
    checkOutput("rstmid_busy", Busy, 0);
    Reset = 1'b0;
    sawValid = 1'b0;
    sawDone = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      tick();
      if (Rd_Valid !== 1'b0) sawValid = 1'b1;
      if (Done !== 1'b0) sawDone = 1'b1;
    end
    checkOutput("rstmid_data_discarded", sawValid, 0);
    checkOutput("rstmid_no_done", sawDone, 0);
    checkOutput("rstmid_cmd_ready", Cmd_Ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
